// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: N-to-1 round-robin AXI4 read arbiter, one burst in flight.
// Ports: m_* per-master AR/R slices, s_* downstream slave, grant/busy/protocol_err status.
module axi_rd_arbiter #(
  parameter int NUM_M  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_M*ADDR_W-1:0]  m_araddr,
  input  logic [NUM_M*8-1:0]       m_arlen,
  input  logic [NUM_M*3-1:0]       m_arsize,
  input  logic [NUM_M*2-1:0]       m_arburst,
  input  logic [NUM_M-1:0]         m_arvalid,
  output logic [NUM_M-1:0]         m_arready,
  output logic [DATA_W-1:0]        m_rdata,
  output logic [1:0]               m_rresp,
  output logic                     m_rlast,
  output logic [NUM_M-1:0]         m_rvalid,
  input  logic [NUM_M-1:0]         m_rready,
  output logic [ADDR_W-1:0]        s_araddr,
  output logic [7:0]               s_arlen,
  output logic [2:0]               s_arsize,
  output logic [1:0]               s_arburst,
  output logic                     s_arvalid,
  input  logic                     s_arready,
  input  logic [DATA_W-1:0]        s_rdata,
  input  logic [1:0]               s_rresp,
  input  logic                     s_rlast,
  input  logic                     s_rvalid,
  output logic                     s_rready,
  output logic [NUM_M-1:0]         grant,
  output logic                     busy,
  output logic                     protocol_err
);

  localparam int PW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } state_t;

  state_t           state;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    gidx;
  logic [PW-1:0]    rr_next;
  logic [NUM_M-1:0] pick_oh;
  logic             pick_vld;
  logic [7:0]       len_q;
  logic [7:0]       beat_cnt;
  logic             in_addr;
  logic             in_data;
  logic             ar_hs;
  logic             r_hs;

  // Binary index of the one-hot grant.
  always_comb begin
    gidx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (grant[i]) gidx = PW'(i);
    end
  end

  // First requester at or after rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx      = 0;
    pick_oh  = '0;
    pick_vld = 1'b0;
    for (int k = 0; k < NUM_M; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_M;
      if (!pick_vld && m_arvalid[idx]) begin
        pick_oh[idx] = 1'b1;
        pick_vld     = 1'b1;
      end
    end
  end

  assign rr_next = (int'(gidx) == NUM_M - 1) ? '0 : gidx + 1'b1;

  assign in_addr = (state == ADDR);
  assign in_data = (state == DATA);
  assign busy    = (state != IDLE);

  assign s_arvalid = in_addr & m_arvalid[gidx];
  assign ar_hs     = s_arvalid & s_arready;
  assign s_rready  = in_data & m_rready[gidx];
  assign r_hs      = s_rready & s_rvalid;

  assign s_araddr  = in_addr ? m_araddr[gidx*ADDR_W +: ADDR_W] : '0;
  assign s_arlen   = in_addr ? m_arlen[gidx*8 +: 8] : '0;
  assign s_arsize  = in_addr ? m_arsize[gidx*3 +: 3] : '0;
  assign s_arburst = in_addr ? m_arburst[gidx*2 +: 2] : '0;
  assign m_arready = (in_addr & s_arready) ? grant : '0;

  assign m_rvalid = (in_data & s_rvalid) ? grant : '0;
  assign m_rdata  = in_data ? s_rdata : '0;
  assign m_rresp  = in_data ? s_rresp : '0;
  assign m_rlast  = in_data & s_rlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      len_q        <= '0;
      beat_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_vld) begin
            grant <= pick_oh;
            state <= ADDR;
          end
        end
        // A dropped ARVALID keeps the grant; no re-arbitration.
        ADDR: begin
          if (ar_hs) begin
            len_q    <= m_arlen[gidx*8 +: 8];
            beat_cnt <= '0;
            state    <= DATA;
          end
        end
        // Only RLAST ends the burst; count mismatch is just flagged.
        DATA: begin
          if (r_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (s_rlast != (beat_cnt == len_q))
              protocol_err <= 1'b1;
            if (s_rlast) begin
              rr_ptr <= rr_next;
              grant  <= '0;
              state  <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule
